i2s_tx_master: RTL and testbench
================================

// Module: i2s_tx_master
// PURPOSE
//  I2S master transmitter: the transmit end of the I2S link whose receive end deserializes into l_out/r_out.
//  Divides clk down to SCLK and generates LRCLK (64 SCLK per frame, 32-bit slots, Philips 1-bit delay).
//  Serializes stereo samples MSB first on SD, and takes them from a 1-entry holding buffer via valid/ready.
//  Drives a DAC or loops back to the sampler's receiver for self-test.
// PARAMETERS
//  SCLK_DIV   4   clk cycles per SCLK half-period; legal >= 2
// PORTS
//  clk           in   1   system clock; all logic on posedge
//  reset_n       in   1   synchronous reset, active low
//  sample_l      in   32  left sample, full 32-bit slot
//  sample_r      in   32  right sample
//  sample_valid  in   1   producer has a stereo pair
//  sample_ready  out  1   holding buffer empty; pair accepted when valid&&ready at posedge clk
//  sclk          out  1   serial bit clock
//  lrclk         out  1   word select: 0=left slot, 1=right slot
//  sd_out        out  1   serial data; changes only on SCLK falling edge
//  frame_start   out  1   1-clk pulse in the clk cycle lrclk falls to 0
//  underrun      out  1   1-clk pulse when a frame loads with an empty buffer
//  underrun_cnt  out  16  saturating count of underruns
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): sclk=0, lrclk=0, sd_out=0, frame_start=0, underrun=0, underrun_cnt=0.
//   Also sample_ready=0, buffer empty, shifter=0, div_cnt=0, bit_pos=63. Mid-frame reset aborts; no partial data kept.
//  sample_ready is registered: 1 in first clk after reset released; 0 while buffer full.
//  Divider: div_cnt counts 0..SCLK_DIV-1; at SCLK_DIV-1 it wraps to 0 and toggles sclk.
//   SCLK period is 2*SCLK_DIV clk. Rise = 0->1 toggle; fall = 1->0 toggle.
//  All of lrclk, sd_out, bit_pos and the shifter update only in the clk cycle sclk falls (same clk edge).
//   The receiver therefore samples mid-bit on the SCLK rise.
//  bit_pos 0..63 advances by 1 (wrap 63->0) at each fall; lrclk <= (new bit_pos >= 32).
//   First fall after reset is bit_pos=0, 2*SCLK_DIV clks after release.
//  Frame bits F[0..63] = {L[31:0], R[31:0]} MSB first. At fall entering bit_pos p: sd_out <= F[(p-1) mod 64].
//   p=0 carries previous frame's R[0]; p=1 carries L[31] (1-bit delay after LRCLK edge).
//  Frame load at fall entering p=1, with the same clk edge as sd_out<=L[31]:
//   - buffer full: the frame takes the buffer pair, buffer empties, sample_ready=1 next clk.
//   - buffer empty: the frame is all zeros, underrun pulses, underrun_cnt += 1 (holds at 16'hFFFF).
//  Accept when valid&&ready in the same clk as a load from an empty buffer:
//   the load still underruns; the accepted pair is buffered for the next frame. No bypass.
//  Accept is impossible while full, so a load and an accept never race on a full buffer.
//   A pair offered while not ready is simply not taken; the producer holds valid.
//  frame_start pulses with the lrclk 1->0 transition (entering p=0), including the first fall after reset.
//  Latency: a pair accepted before the p=1 fall of frame N starts on SD at that fall.
//   Its last bit, R[0], appears at p=0 of frame N+1.
// TESTING
//  T1 SCLK_DIV=2; after reset: sclk period = 4 clk; lrclk low for 32 SCLK periods then high for 32.
//   frame_start every 256 clk.
//  T2 Offer L=32'h8000_0001, R=32'h7FFF_FFFE before first p=1: SD bits p1..p32 = 1,0x30,1.
//   SD bits p33..p63 then p0 of next frame = 0,1x30,0.
//  T3 Loopback into i2s receiver: back-to-back pairs A5A5_0F0F/1234_5678, then DEAD_BEEF/CAFE_F00D.
//   Receiver sees both pairs in order; underrun never pulses.
//  T4 No valid for 3 frames: SD all zeros, 3 underrun pulses, underrun_cnt=3, sample_ready stays 1.
//  T5 Assert valid in exact clk of p=1 load with empty buffer: underrun=1.
//   Pair transmits in following frame; sample_ready=0 until that load.
//  T6 Reset at bit_pos 40: next clk all outputs at reset values.
//   After release, first fall is p=0 with frame_start; prior buffered pair is lost (all-zero frame, underrun).

Source files
------------

// File: rtl/i2s_tx_master.sv
// I2S master transmitter.
// Divides clk down to a bit clock and generates a 64-bit Philips frame (two 32-bit slots,
// data delayed one bit after the word-select edge). Samples come from a one-entry
// holding buffer through a valid/ready handshake. A frame that loads from an empty
// buffer is sent as zeros and is counted as an underrun.
module i2s_tx_master #(
    parameter int SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] sample_l,
    input  logic [31:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        sclk,
    output logic        lrclk,
    output logic        sd_out,
    output logic        frame_start,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    localparam int               DIV_W    = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    // Registered state
    logic [DIV_W-1:0] div_cnt_reg,      div_cnt_next;
    logic             sclk_reg,         sclk_next;
    logic [5:0]       bit_pos_reg,      bit_pos_next;
    logic             lrclk_reg,        lrclk_next;
    logic             sd_reg,           sd_next;
    logic [63:0]      shifter_reg,      shifter_next;
    logic             frame_start_reg,  frame_start_next;
    logic             underrun_reg,     underrun_next;
    logic [15:0]      underrun_cnt_reg, underrun_cnt_next;
    logic             buf_full_reg,     buf_full_next;
    logic [31:0]      buf_l_reg,        buf_l_next;
    logic [31:0]      buf_r_reg,        buf_r_next;
    logic             sample_ready_reg, sample_ready_next;

    // Decoded events for the current clk cycle
    logic        sclk_toggle;
    logic        sclk_fall;
    logic        frame_load;
    logic        accept;
    logic [63:0] frame_word;

    // Event decode: divider wrap, bit-clock fall, frame load slot and handshake
    always_comb begin
        sclk_toggle = (div_cnt_reg == DIV_LAST);
        sclk_fall   = sclk_toggle && sclk_reg;
        // The load happens at the fall that enters bit 1, right after the LRCLK edge
        frame_load  = sclk_fall && (bit_pos_reg == 6'd0);
        accept      = sample_valid && sample_ready_reg;
        frame_word  = buf_full_reg ? {buf_l_reg, buf_r_reg} : 64'd0;
    end

    // Bit-clock divider: toggles sclk every SCLK_DIV clk cycles
    always_comb begin
        div_cnt_next = div_cnt_reg + DIV_W'(1);
        sclk_next    = sclk_reg;
        if (sclk_toggle) begin
            div_cnt_next = '0;
            sclk_next    = ~sclk_reg;
        end
    end

    // Serializer: bit position, word select and data all move on the sclk fall
    always_comb begin
        bit_pos_next     = bit_pos_reg;
        lrclk_next       = lrclk_reg;
        sd_next          = sd_reg;
        shifter_next     = shifter_reg;
        frame_start_next = 1'b0;
        if (sclk_fall) begin
            // 6-bit add wraps 63 -> 0 on its own
            bit_pos_next     = bit_pos_reg + 6'd1;
            lrclk_next       = bit_pos_next[5];
            frame_start_next = (bit_pos_reg == 6'd63);
            if (frame_load) begin
                // L[31] goes out now; the remaining 63 bits wait in the shifter
                sd_next      = frame_word[63];
                shifter_next = {frame_word[62:0], 1'b0};
            end else begin
                // At bit 0 this emits the previous frame's R[0]
                sd_next      = shifter_reg[63];
                shifter_next = {shifter_reg[62:0], 1'b0};
            end
        end
    end

    // Holding buffer and underrun accounting
    always_comb begin
        buf_full_next     = buf_full_reg;
        buf_l_next        = buf_l_reg;
        buf_r_next        = buf_r_reg;
        underrun_next     = frame_load && !buf_full_reg;
        underrun_cnt_next = underrun_cnt_reg;
        if (underrun_next && (underrun_cnt_reg != 16'hFFFF)) begin
            underrun_cnt_next = underrun_cnt_reg + 16'd1;
        end
        if (frame_load && buf_full_reg) begin
            buf_full_next = 1'b0;
        end
        // Ready implies empty, so an accept never collides with a load from a full
        // buffer; an accept during an underrun load simply fills it for the next frame.
        if (accept) begin
            buf_full_next = 1'b1;
            buf_l_next    = sample_l;
            buf_r_next    = sample_r;
        end
        sample_ready_next = ~buf_full_next;
    end

    // State register with synchronous active-low reset; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_reg      <= '0;
            sclk_reg         <= 1'b0;
            bit_pos_reg      <= 6'd63;
            lrclk_reg        <= 1'b0;
            sd_reg           <= 1'b0;
            shifter_reg      <= 64'd0;
            frame_start_reg  <= 1'b0;
            underrun_reg     <= 1'b0;
            underrun_cnt_reg <= 16'd0;
            buf_full_reg     <= 1'b0;
            buf_l_reg        <= 32'd0;
            buf_r_reg        <= 32'd0;
            sample_ready_reg <= 1'b0;
        end else begin
            div_cnt_reg      <= div_cnt_next;
            sclk_reg         <= sclk_next;
            bit_pos_reg      <= bit_pos_next;
            lrclk_reg        <= lrclk_next;
            sd_reg           <= sd_next;
            shifter_reg      <= shifter_next;
            frame_start_reg  <= frame_start_next;
            underrun_reg     <= underrun_next;
            underrun_cnt_reg <= underrun_cnt_next;
            buf_full_reg     <= buf_full_next;
            buf_l_reg        <= buf_l_next;
            buf_r_reg        <= buf_r_next;
            sample_ready_reg <= sample_ready_next;
        end
    end

    assign sample_ready = sample_ready_reg;
    assign sclk         = sclk_reg;
    assign lrclk        = lrclk_reg;
    assign sd_out       = sd_reg;
    assign frame_start  = frame_start_reg;
    assign underrun     = underrun_reg;
    assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Testbench for i2s_tx_master: table of per-frame offers with expected frames and
// underruns, plus hand-written sequences for the load-cycle accept and mid-frame reset.
module tb_i2s_tx_master;

    localparam int SCLK_DIV = 2;
    localparam int NV       = 7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] sample_l;
    logic [31:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        sclk;
    logic        lrclk;
    logic        sd_out;
    logic        frame_start;
    logic        underrun;
    logic [15:0] underrun_cnt;

    i2s_tx_master #(.SCLK_DIV(SCLK_DIV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sd_out       (sd_out),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- receiver / frame monitor (samples 1 time unit after posedge) ----------
    int unsigned cyc = 0, last_fs_cyc = 0, last_interval = 0;
    int unsigned lr_high_acc = 0, last_lr_high = 0, rise_acc = 0, last_rises = 0;
    int unsigned fs_total = 0, ur_total = 0;
    logic        sclk_prev = 1'b0, prev_lr = 1'b0;
    logic [63:0] rx_sh = 64'd0;
    logic [63:0] rx_frames [int];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset_n) begin
            sclk_prev = 1'b0;
            prev_lr   = 1'b0;
            rx_sh     = 64'd0;
        end else begin
            if (frame_start) begin
                fs_total++;
                last_interval = cyc - last_fs_cyc;
                last_fs_cyc   = cyc;
                last_lr_high  = lr_high_acc;
                last_rises    = rise_acc;
                lr_high_acc   = 0;
                rise_acc      = 0;
            end
            if (lrclk) lr_high_acc++;
            if (underrun) ur_total++;
            if (sclk && !sclk_prev) begin
                rise_acc++;
                rx_sh = {rx_sh[62:0], sd_out};
                // Rise at bit 0 of the next frame completes the previous frame
                if (!lrclk && prev_lr) rx_frames[int'(fs_total) - 1] = rx_sh;
                prev_lr = lrclk;
            end
            sclk_prev = sclk;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 600);
        if (!frame_start) begin
            n_total++;
            $display("FAIL wait_fs: no frame_start within %0d clk", n);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_sclk"},         sclk,         0);
        check({pfx, "_lrclk"},        lrclk,        0);
        check({pfx, "_sd"},           sd_out,       0);
        check({pfx, "_frame_start"},  frame_start,  0);
        check({pfx, "_underrun"},     underrun,     0);
        check({pfx, "_underrun_cnt"}, underrun_cnt, 0);
        check({pfx, "_ready"},        sample_ready, 0);
    endtask

    task automatic offer(input logic [31:0] l, input logic [31:0] r);
        int t;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        t = 0;
        while (!sample_ready && t < 8) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        check("offer_taken_ready_low", sample_ready, 0);
    endtask

    typedef struct packed {
        logic        offer;
        logic [31:0] l;
        logic [31:0] r;
        logic [63:0] exp_frame;
        logic [7:0]  exp_ur;
    } vec_t;

    typedef struct packed {
        logic [31:0] id;
        logic [63:0] val;
    } expf_t;

    vec_t  vecs [NV];
    expf_t exp_q [$];

    initial begin
        int          n;
        int unsigned ur_base;
        logic [63:0] got;

        vecs[0] = '{1'b1, 32'h8000_0001, 32'h7FFF_FFFE, 64'h8000_0001_7FFF_FFFE, 8'd0};
        vecs[1] = '{1'b1, 32'hA5A5_0F0F, 32'h1234_5678, 64'hA5A5_0F0F_1234_5678, 8'd0};
        vecs[2] = '{1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 8'd0};
        vecs[3] = '{1'b0, 32'h0,         32'h0,         64'h0,                   8'd1};
        vecs[4] = '{1'b0, 32'h0,         32'h0,         64'h0,                   8'd1};
        vecs[5] = '{1'b0, 32'h0,         32'h0,         64'h0,                   8'd1};
        vecs[6] = '{1'b1, 32'h0000_0001, 32'h8000_0000, 64'h0000_0001_8000_0000, 8'd0};

        reset_n = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
        repeat (3) @(negedge clk);
        check_reset("rst");

        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", sample_ready, 1);
        wait_fs(n);
        check("first_fall_delay", 64'(n + 1), 64'(2 * SCLK_DIV));
        check("first_fs_lrclk", lrclk, 0);
        check("first_fs_sd", sd_out, 0);

        // Table: one frame per entry, offer (if any) right after frame_start
        for (int i = 0; i < NV; i++) begin
            if (i > 0) begin
                wait_fs(n);
                check($sformatf("vec%0d_underruns", i - 1), 64'(ur_total - ur_base),
                      64'(vecs[i - 1].exp_ur));
            end
            ur_base = ur_total;
            exp_q.push_back('{fs_total, vecs[i].exp_frame});
            $display("vec %0d: frame %0d offer=%0b L=%h R=%h", i, fs_total,
                     vecs[i].offer, vecs[i].l, vecs[i].r);
            if (vecs[i].offer) offer(vecs[i].l, vecs[i].r);
            else check($sformatf("vec%0d_idle_ready", i), sample_ready, 1);
        end
        wait_fs(n);
        check("vec6_underruns", 64'(ur_total - ur_base), 64'(vecs[NV - 1].exp_ur));
        check("underrun_cnt_after_idle", underrun_cnt, 3);
        check("frame_period_clk", 64'(last_interval), 64'(128 * SCLK_DIV));
        check("lrclk_high_clk", 64'(last_lr_high), 64'(64 * SCLK_DIV));
        check("sclk_rises_per_frame", 64'(last_rises), 64);

        // Accept in the exact clk of a load from an empty buffer
        exp_q.push_back('{fs_total, 64'h0});
        repeat (3) @(negedge clk);
        check("t5_ready_before", sample_ready, 1);
        sample_l = 32'h1357_9BDF; sample_r = 32'h2468_ACE0; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        $display("t5: offer in load clk L=%h R=%h", sample_l, sample_r);
        check("t5_underrun_pulse", underrun, 1);
        check("t5_ready_low", sample_ready, 0);
        check("t5_underrun_cnt", underrun_cnt, 4);
        wait_fs(n);
        exp_q.push_back('{fs_total, 64'h1357_9BDF_2468_ACE0});
        check("t5_ready_held", sample_ready, 0);
        repeat (3) @(negedge clk);
        check("t5_ready_before_load", sample_ready, 0);
        @(negedge clk);
        check("t5_ready_after_load", sample_ready, 1);
        check("t5_no_underrun", underrun, 0);

        // Mid-frame reset at bit 40 with a pair sitting in the buffer
        wait_fs(n);
        repeat (5) @(negedge clk);
        offer(32'h0BAD_F00D, 32'h600D_CAFE);
        $display("t6: buffered L=0BADF00D R=600DCAFE before reset");
        n = 0;
        while (!lrclk && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (33) @(negedge clk);
        check("t6_lrclk_pre", lrclk, 1);
        check("t6_cnt_pre", underrun_cnt, 5);
        check("t6_ready_pre", sample_ready, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset("t6_rst");
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after_release", sample_ready, 1);
        wait_fs(n);
        check("t6_first_fall_delay", 64'(n + 1), 64'(2 * SCLK_DIV));
        check("t6_fs_lrclk", lrclk, 0);
        exp_q.push_back('{fs_total, 64'h0});
        repeat (4) @(negedge clk);
        check("t6_underrun_pulse", underrun, 1);
        check("t6_underrun_cnt", underrun_cnt, 1);
        wait_fs(n);
        repeat (4) @(negedge clk);

        foreach (exp_q[k]) begin
            got = rx_frames.exists(int'(exp_q[k].id)) ? rx_frames[int'(exp_q[k].id)] : 64'hx;
            $display("frame %0d: received %h", exp_q[k].id, got);
            check($sformatf("frame%0d_data", exp_q[k].id), got, exp_q[k].val);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
